// File: rtl/neuron_pkg.sv
// neuron_pkg: shared widths, FSM state encoding and saturation bounds for the neuron MAC datapath.
package neuron_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF = 22;
   localparam int CNT_W_DEF = 7;
   localparam int PTR_W = 6;
   localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
   localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};
   typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, COMPARE, DONE} mac_state_t;
endpackage

// File: rtl/neuron_mac_pipe.sv
// neuron_mac_pipe: stage-1 product register and stage-2 accumulator of the neuron MAC.
// NEURON_MAC_SATURATE_EN selects clamping arithmetic with a sticky acc_sat instead of wrap-around.
module neuron_mac_pipe
   import neuron_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic cap,
   input  logic acc_en,
   input  logic [PTR_W-1:0] ptr,
   input  logic signed [DATA_W-1:0] data,
   input  logic signed [DATA_W-1:0] weight,
   output logic signed [ACC_W-1:0] acc,
   output logic [CNT_W-1:0] cnt,
   output logic [PTR_W-1:0] last_ptr
`ifdef NEURON_MAC_SATURATE_EN
   ,
   output logic acc_sat
`endif
);
   logic signed [2*DATA_W-1:0] prod;
   logic p_vld;
   logic [PTR_W-1:0] p_ptr;
   logic signed [ACC_W-1:0] acc_nx;

   // a capture without accumulate still refreshes prod but leaves p_vld low
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         prod <= '0;
         p_vld <= 1'b0;
         p_ptr <= '0;
      end else if (clr) begin
         p_vld <= 1'b0;
      end else begin
         p_vld <= cap & acc_en;
         if (cap) begin
            prod <= (2*DATA_W)'(data) * (2*DATA_W)'(weight);
            p_ptr <= ptr;
         end
      end

`ifdef NEURON_MAC_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   logic signed [ACC_W:0] sum;
   logic ovf;
   assign sum = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
   assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
   assign acc_nx = ovf ? (sum[ACC_W] ? SAT_MIN : SAT_MAX) : sum[ACC_W-1:0];
   always_ff @(posedge clk or posedge rst)
      if (rst) acc_sat <= 1'b0;
      else if (clr) acc_sat <= 1'b0;
      else if (p_vld & ovf) acc_sat <= 1'b1;
`else
   assign acc_nx = acc + ACC_W'(prod);
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc <= '0;
         cnt <= '0;
         last_ptr <= '0;
      end else if (clr) begin
         acc <= '0;
         cnt <= '0;
         last_ptr <= '0;
      end else if (p_vld) begin
         acc <= acc_nx;
         cnt <= cnt + 1'b1;
         last_ptr <= p_ptr;
      end
endmodule

// File: rtl/neuron_mac_accumulator.sv
// neuron_mac_accumulator: burst multiply-accumulate with threshold compare and held result.
// Defining NEURON_MAC_SATURATE_EN adds clamping accumulation and the acc_sat output.
module neuron_mac_accumulator
   import neuron_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic rst_mem,
   input  logic mul_mem_en,
   input  logic ac_mem_en,
   input  logic [PTR_W-1:0] rd_data_ptr,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic signed [DATA_W-1:0] weight_in,
   input  logic signed [ACC_W-1:0] threshold_in,
   input  logic threshold_load,
   input  logic result_ack,
   output logic signed [ACC_W-1:0] acc_out,
   output logic neuron_fire,
   output logic result_valid,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [PTR_W-1:0] last_ptr,
   output logic busy
`ifdef NEURON_MAC_SATURATE_EN
   ,
   output logic acc_sat
`endif
);
   mac_state_t state, nxt;
   logic signed [ACC_W-1:0] thr;
   logic cap;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = mul_mem_en ? ACCUM : IDLE;
         ACCUM:   nxt = mul_mem_en ? ACCUM : DRAIN;
         DRAIN:   nxt = COMPARE;
         COMPARE: nxt = DONE;
         DONE:    nxt = result_ack ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
      if (rst_mem) nxt = IDLE;
   end

   // operands are only taken while a burst may start or continue
   assign cap = mul_mem_en & (state == IDLE || state == ACCUM);
   assign busy = state == ACCUM || state == DRAIN;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         thr <= '0;
         neuron_fire <= 1'b0;
         result_valid <= 1'b0;
      end else if (rst_mem) begin
         neuron_fire <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         if (threshold_load) thr <= threshold_in;
         if (state == COMPARE) begin
            neuron_fire <= acc_out >= thr;
            result_valid <= 1'b1;
         end else if (state == DONE && result_ack) begin
            result_valid <= 1'b0;
         end
      end

   neuron_mac_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_pipe (
      .clk(clk),
      .rst(rst),
      .clr(rst_mem),
      .cap(cap),
      .acc_en(ac_mem_en),
      .ptr(rd_data_ptr),
      .data(data_in),
      .weight(weight_in),
      .acc(acc_out),
      .cnt(sample_cnt),
      .last_ptr(last_ptr)
`ifdef NEURON_MAC_SATURATE_EN
      ,
      .acc_sat(acc_sat)
`endif
   );
endmodule

// File: doc/neuron_mac_accumulator.md
Name: neuron_mac_accumulator

Overview:
- Datapath stage directly downstream of the control unit. Consumes its mul_mem_en, ac_mem_en, rd_data_ptr and rst_mem outputs, plus operand words read from the data/weight memories.
- Multiplies each data word by its weight and accumulates the signed products. At the end of the compute burst it compares the sum with the loaded threshold.
- Presents the sum, a fire flag and a held result_valid to the output/readout logic.

Parameters:
- DATA_W, 8, signed width of data_in and weight_in
- ACC_W, 22, signed accumulator width (2*DATA_W + 6 covers 64 full-scale products)
- CNT_W, 7, width of the sample counter (counts 0..64)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rst_mem  in  1  synchronous clear of accumulator, counter and result
- mul_mem_en  in  1  operand pair valid this cycle; capture product
- ac_mem_en  in  1  accumulate enable, sampled with mul_mem_en
- rd_data_ptr  in  6  address of the current operand pair
- data_in  in  DATA_W  signed data word at rd_data_ptr, same cycle
- weight_in  in  DATA_W  signed weight at rd_data_ptr, same cycle
- threshold_in  in  ACC_W  signed threshold value
- threshold_load  in  1  latch threshold_in
- result_ack  in  1  readout consumed result; return to IDLE
- acc_out  out  ACC_W  accumulated sum (registered)
- neuron_fire  out  1  1 when acc_out >= threshold (signed)
- result_valid  out  1  acc_out/neuron_fire final and stable
- sample_cnt  out  CNT_W  number of products accumulated
- last_ptr  out  6  rd_data_ptr of the most recent accumulated pair
- busy  out  1  high in ACCUM and DRAIN

Behaviour:
- Reset (rst) is asynchronous; all registers go to 0. acc_out=0, neuron_fire=0, result_valid=0, sample_cnt=0, last_ptr=0, busy=0, threshold register=0, state=IDLE.
- Stage 1: when mul_mem_en=1, register prod = data_in*weight_in (signed, 2*DATA_W bits). Register p_vld = mul_mem_en & ac_mem_en and p_ptr = rd_data_ptr.
- Stage 2: when p_vld=1, acc <= acc + sign_extend(prod), sample_cnt++, last_ptr <= p_ptr. An operand presented in cycle N therefore appears in acc_out at the end of cycle N+1.
- mul_mem_en=1 with ac_mem_en=0: the product is captured but not accumulated.
- Threshold: threshold_load=1 latches threshold_in in any state. A load that arrives during COMPARE takes effect only on the next compare.
- States:
  - IDLE: acc held. The first cycle with mul_mem_en=1 moves to ACCUM. Pipeline stage 1 is active in that same cycle.
  - ACCUM: stays while mul_mem_en=1. The first cycle with mul_mem_en=0 moves to DRAIN.
  - DRAIN: exactly one cycle, so the last product is accumulated. Then goes to COMPARE.
  - COMPARE: one cycle. Registers neuron_fire = ($signed(acc) >= $signed(threshold)) and sets result_valid=1. Then goes to DONE.
  - DONE: result_valid, acc_out and neuron_fire are held. result_ack=1 clears result_valid and goes to IDLE; acc is kept until rst_mem. mul_mem_en=1 in DONE is ignored (no capture) until ack.
- rst_mem=1 in any state: acc, sample_cnt, last_ptr, neuron_fire, result_valid and p_vld are cleared, state goes to IDLE. The threshold is retained. rst_mem has priority over every other input in the same cycle.
- result_ack outside DONE is ignored.
- Overflow: without the optional feature, the sum wraps modulo 2^ACC_W.
- A new burst started from IDLE without rst_mem continues the accumulation from the held value (deliberate; this supports multi-burst neurons).

Optional Feature:
- Macro: NEURON_MAC_SATURATE_EN.
- When defined: each accumulate clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)). A sticky output acc_sat (1 bit) is added; it sets on any clamp and clears on rst/rst_mem.
- When undefined: wrap-around arithmetic, and the acc_sat port does not exist.

Decomposition:
- Package neuron_pkg holds:
  - DATA_W/ACC_W/CNT_W defaults
  - mac_state_t enum {IDLE, ACCUM, DRAIN, COMPARE, DONE} (logic [2:0])
  - ACC_MAX/ACC_MIN localparams for saturation
- One natural sub-module: neuron_mac_pipe (the stage-1 multiply register and stage-2 adder, with the saturation logic). The FSM and compare stay in the top.

Test Plan:
- Basic burst: load threshold=100; 63 cycles mul_mem_en=ac_mem_en=1, data=2, weight=1, ptr 0..62. Expect acc_out=126, sample_cnt=63, last_ptr=62, neuron_fire=1, result_valid exactly 3 cycles after mul_mem_en falls.
- Negative/below threshold: data=-3, weight=5 for 10 cycles, threshold=0. Expect acc_out=-150, neuron_fire=0, and result_valid held until result_ack, then IDLE.
- Gaps: ac_mem_en=0 on alternate cycles, data=weight=1 for 8 cycles. Expect acc_out=4, sample_cnt=4.
- rst_mem mid-ACCUM at cycle 20: expect all outputs 0 next cycle, threshold retained, and a following 5-cycle burst (1*1) gives acc_out=5.
- Async rst asserted in DONE between clock edges: outputs go 0 immediately, state IDLE.
- Overflow: 64 cycles of data=-128, weight=-128 with ACC_W=16 override. Without the macro, expect the wrapped value 0x0000. With NEURON_MAC_SATURATE_EN, expect acc_out=32767 and acc_sat=1.
